uart_cmd_wrapper: RTL and testbench



---
 rtl/uart_cmd_wrapper.sv | 189 ++++++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_wrapper.sv
// Host UART front end: receives two-byte commands (high byte first) and
// serialises 8-bit responses back to the host. RX and TX are independent.
module uart_cmd_wrapper #(
  parameter int unsigned BAUD_DIV = 108,
  parameter int unsigned TO_BITS  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int unsigned CW = $clog2(BAUD_DIV * TO_BITS) + 1;
  localparam logic [CW-1:0] BIT_M1  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] TO_M1   = CW'(BAUD_DIV * TO_BITS - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {RX_IDLE, RX_RECV}     rx_state_t;
  typedef enum logic {WAIT_HIGH, WAIT_LOW}  asm_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT}     tx_state_t;

  rx_state_t   rx_state;
  asm_state_t  asm_state;
  tx_state_t   tx_state;

  logic          rx_s1, rx_s2, rx_prev;
  logic          start_edge;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_byte;
  logic          byte_rdy;
  logic          frame_err;

  logic [7:0]    hi_byte;
  logic [CW-1:0] to_cnt;
  logic          to_run;

  logic [8:0]    tx_data;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_left;

  assign start_edge = (rx_state == RX_IDLE) && rx_prev && !rx_s2;

  // RX synchronizer and frame receiver; samples land mid-bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= RX;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (start_edge) begin
            rx_state <= RX_RECV;
            rx_cnt   <= HALF_M1;
            rx_bit   <= '0;
          end
        end
        RX_RECV: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end else begin
            rx_cnt <= BIT_M1;
            if (rx_bit == 4'd0) begin
              if (rx_s2) rx_state <= RX_IDLE;
              else       rx_bit   <= 4'd1;
            end else if (rx_bit == 4'd9) begin
              rx_state <= RX_IDLE;
              if (rx_s2) begin
                byte_rdy <= 1'b1;
                rx_byte  <= rx_shift;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              rx_shift <= {rx_s2, rx_shift[7:1]};
              rx_bit   <= rx_bit + 4'd1;
            end
          end
        end
      endcase
    end
  end

  // Command assembly; the completing set is written last so it beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_state <= WAIT_HIGH;
      hi_byte   <= '0;
      to_cnt    <= '0;
      to_run    <= 1'b0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
    end else begin
      if (clr_cmd_rdy || (start_edge && asm_state == WAIT_HIGH))
        cmd_rdy <= 1'b0;
      case (asm_state)
        WAIT_HIGH: begin
          if (byte_rdy) begin
            hi_byte   <= rx_byte;
            to_cnt    <= TO_M1;
            to_run    <= 1'b1;
            asm_state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (frame_err) begin
            to_run    <= 1'b0;
            asm_state <= WAIT_HIGH;
          end else if (byte_rdy) begin
            cmd       <= {hi_byte, rx_byte};
            cmd_rdy   <= 1'b1;
            to_run    <= 1'b0;
            asm_state <= WAIT_HIGH;
          end else if (start_edge) begin
            to_run <= 1'b0;
          end else if (to_run) begin
            if (to_cnt == '0) begin
              to_run    <= 1'b0;
              asm_state <= WAIT_HIGH;
            end else begin
              to_cnt <= to_cnt - CNT_ONE;
            end
          end
        end
      endcase
    end
  end

  // Start bit goes straight to TX, so only {stop, data} is kept in the shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TX        <= 1'b1;
      tx_state  <= TX_IDLE;
      tx_data   <= '1;
      tx_cnt    <= '0;
      tx_left   <= '0;
      resp_sent <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_data   <= {1'b1, resp};
            TX        <= 1'b0;
            tx_cnt    <= BIT_M1;
            tx_left   <= 4'd9;
            resp_sent <= 1'b0;
            tx_state  <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end else if (tx_left != 4'd0) begin
            TX      <= tx_data[0];
            tx_data <= {1'b1, tx_data[8:1]};
            tx_cnt  <= BIT_M1;
            tx_left <= tx_left - 4'd1;
          end else begin
            TX        <= 1'b1;
            resp_sent <= 1'b1;
            tx_state  <= TX_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper: directed scenarios plus random
// byte streams compared against a frame-level command/response model.
`timescale 1ns/1ps
module tb_uart_cmd_wrapper;

  localparam int BD    = 108;
  localparam int TO    = 32;
  localparam int FRAME = 10 * BD;
  // Line falls at negedge 0; the receiver sees it 3 clocks later (2-flop sync
  // plus edge), samples the start BD/2 later and the stop 9*BD after that.
  localparam int STOP_SMP = 3 + BD / 2 + 9 * BD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  bit          m_pending;
  logic [7:0]  m_hi;
  logic [15:0] m_cmd;
  bit          m_rdy;

  uart_cmd_wrapper #(.BAUD_DIV(BD), .TO_BITS(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_hi      = '0;
    m_cmd     = '0;
    m_rdy     = 1'b0;
  endtask

  // gap = idle bit-times between previous frame end and this frame's start
  task automatic rx_model(input logic [7:0] b, input bit good, input int gap);
    if (m_pending && (gap * BD + BD / 2 > TO * BD)) m_pending = 1'b0;
    if (!m_pending) m_rdy = 1'b0;
    if (!good) begin
      m_pending = 1'b0;
    end else if (m_pending) begin
      m_cmd     = {m_hi, b};
      m_rdy     = 1'b1;
      m_pending = 1'b0;
    end else begin
      m_hi      = b;
      m_pending = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input bit chk_drop, input bit chk_done, input bit clr_done);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int j = 0; j < FRAME; j++) begin
      RX = fr[j / BD];
      if (chk_drop && j == 4) chk("rdy_drop_at_start", 32'(cmd_rdy), 0);
      if (j == STOP_SMP) begin
        if (chk_done) chk("rdy_before_set", 32'(cmd_rdy), 0);
        if (clr_done) clr_cmd_rdy = 1'b1;
      end
      if (j == STOP_SMP + 1) begin
        clr_cmd_rdy = 1'b0;
        if (chk_done) chk("rdy_set_edge", 32'(cmd_rdy), 1);
      end
      @(negedge clk);
    end
  endtask

  task automatic rx_step(input logic [7:0] b, input bit good, input int gap,
                         input bit chk_drop, input bit chk_done, input bit clr_done);
    RX = 1'b1;
    repeat (gap * BD) @(negedge clk);
    rx_model(b, good, gap);
    send_frame(b, good, chk_drop, chk_done, clr_done);
    repeat (2) @(negedge clk);
    chk("rx_cmd", 32'(cmd), 32'(m_cmd));
    chk("rx_rdy", 32'(cmd_rdy), 32'(m_rdy));
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    @(negedge clk);
    chk("clr_rdy", 32'(cmd_rdy), 0);
  endtask

  task automatic tx_frame(input logic [7:0] d, input bit intrude);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    resp = d;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    for (int j = 0; j < FRAME; j++) begin
      if (j == 0) chk("tx_sent_clr", 32'(resp_sent), 0);
      if ((j % BD == 0) || (j % BD == BD - 1)) chk("tx_bit", 32'(TX), 32'(fr[j / BD]));
      if (intrude && j == 500) begin
        resp = ~d;
        send_resp = 1'b1;
      end
      if (intrude && j == 501) send_resp = 1'b0;
      if (j == FRAME - 1) chk("tx_sent_early", 32'(resp_sent), 0);
      @(negedge clk);
    end
    chk("tx_sent", 32'(resp_sent), 1);
    chk("tx_stop", 32'(TX), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic [9:0] fr;
    bit         good;
    bit         prev_bad;
    int         gap;

    rst_n = 1'b0;
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    resp = '0;
    model_reset();
    repeat (5) @(negedge clk);
    chk("rst_tx", 32'(TX), 1);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_rdy", 32'(cmd_rdy), 0);
    chk("rst_sent", 32'(resp_sent), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // two-byte command, exact rise cycle, hold, then clear
    rx_step(8'h41, 1, 2, 0, 0, 0);
    rx_step(8'h10, 1, 1, 0, 1, 0);
    chk("t1_cmd", 32'(cmd), 'h4110);
    repeat (50) @(negedge clk);
    chk("t1_hold", 32'(cmd_rdy), 1);
    pulse_clr();
    chk("t1_cmd_kept", 32'(cmd), 'h4110);

    // uncleared cmd_rdy drops at next high start; clear on set cycle loses
    rx_step(8'h12, 1, 1, 0, 0, 0);
    rx_step(8'h34, 1, 1, 0, 0, 0);
    rx_step(8'h40, 1, 1, 1, 0, 0);
    rx_step(8'h13, 1, 1, 0, 1, 1);
    chk("t2_cmd", 32'(cmd), 'h4013);
    chk("t2_rdy", 32'(cmd_rdy), 1);

    // timeout drops a lone high byte
    rx_step(8'h81, 1, 1, 0, 0, 0);
    rx_step(8'h00, 1, 33, 0, 0, 0);
    chk("t3_no_8100", 32'(cmd), 'h4013);
    rx_step(8'h08, 1, 1, 0, 0, 0);
    chk("t3_cmd", 32'(cmd), 'h0008);

    // framing error on the low byte forces resync
    rx_step(8'h22, 1, 1, 0, 0, 0);
    rx_step(8'h5E, 0, 1, 0, 0, 0);
    rx_step(8'hAB, 1, 1, 0, 0, 0);
    rx_step(8'hCD, 1, 1, 0, 0, 0);
    chk("t4_cmd", 32'(cmd), 'hABCD);

    // start glitch: clears cmd_rdy, produces no byte
    RX = 1'b0;
    repeat (10) @(negedge clk);
    RX = 1'b1;
    m_rdy = 1'b0;
    repeat (FRAME) @(negedge clk);
    chk("glitch_rdy", 32'(cmd_rdy), 0);
    chk("glitch_cmd", 32'(cmd), 'hABCD);
    rx_step(8'h12, 1, 1, 0, 0, 0);
    rx_step(8'h34, 1, 1, 0, 0, 0);
    chk("glitch_sync", 32'(cmd), 'h1234);

    // random byte stream
    prev_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      gap  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(33, 35)) : int'($urandom_range(0, 4));
      if (prev_bad && gap == 0) gap = 1;
      rx_step(b, good, gap, 0, 0, 0);
      prev_bad = !good;
      if ($urandom_range(0, 3) == 0) pulse_clr();
    end

    // transmit 0xA5 with an ignored strobe mid-frame, then random frames
    tx_frame(8'hA5, 1);
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
        chk("tx_idle", 32'(TX), 1);
      end
      tx_frame(8'($urandom), ($urandom_range(0, 1) == 1));
    end

    // full duplex
    fork
      tx_frame(8'h3C, 0);
      begin
        rx_step(8'h7E, 1, 34, 0, 0, 0);
        rx_step(8'h81, 1, 0, 0, 0, 0);
      end
    join
    chk("duplex_cmd", 32'(cmd), 'h7E81);

    // reset mid-frame on both paths
    rx_step(8'h5A, 1, 34, 0, 0, 0);
    rx_step(8'hC3, 1, 1, 0, 0, 0);
    chk("pre_rst_cmd", 32'(cmd), 'h5AC3);
    resp = 8'hF0;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    fr = {1'b1, 8'h5A, 1'b0};
    for (int j = 0; j < 500; j++) begin
      RX = fr[j / BD];
      @(negedge clk);
    end
    chk("pre_rst_tx", 32'(TX), 0);
    rst_n = 1'b0;
    RX = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(TX), 1);
    chk("mid_rst_rdy", 32'(cmd_rdy), 0);
    chk("mid_rst_sent", 32'(resp_sent), 0);
    chk("mid_rst_cmd", 32'(cmd), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    rx_step(8'h00, 1, 1, 0, 0, 0);
    rx_step(8'h00, 1, 1, 0, 1, 0);
    chk("post_rst_cmd", 32'(cmd), 0);
    chk("post_rst_rdy", 32'(cmd_rdy), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
